fetch_unit: RTL and testbench

- PC-generating initiator that drives the instruction memory's PC input and captures the returned Instr into the IF/ID pipeline register.
- Owns next-PC selection: sequential, branch/jump redirect, exception vector, eret return.
- Tags fetched words with branch-delay-slot and fetch-exception information for the downstream pipeline.

---
 rtl/fetch_unit_pkg.sv | 33 +++
 rtl/fetch_unit_addr_check.sv | 33 +++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   RESET_PC / HANDLER_PC : default fetch addresses after reset / on exception
//   EXC_NONE / EXC_ADEL   : fetch exception codes carried into D
//   NOP                   : all-zero instruction word used for bubbles
//   ifid_t                : IF/ID pipeline register bundle
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code;
  } ifid_t;

  // Empty IF/ID entry that still carries a meaningful PC for CP0.
  function automatic ifid_t ifid_bubble(input logic [31:0] pc);
    ifid_t b;
    b.instr    = NOP;
    b.pc       = pc;
    b.bd       = 1'b0;
    b.exc_code = EXC_NONE;
    return b;
  endfunction

endpackage

// File: rtl/fetch_unit_addr_check.sv
// fetch_addr_check: combinational fetch address check (AdEL).
// Built only when FETCH_ADEL_CHECK_EN is defined.
//   pc       in  32  fetch address being presented to instruction memory
//   exc_code out 5   EXC_ADEL if pc is misaligned or outside
//                    [RESET_PC, RESET_PC + 4*2^ADR_BITS), else EXC_NONE
`ifdef FETCH_ADEL_CHECK_EN
module fetch_addr_check #(
  parameter logic [31:0] RESET_PC = fetch_unit_pkg::RESET_PC,
  parameter int          ADR_BITS = 12
) (
  input  logic [31:0] pc,
  output logic [4:0]  exc_code
);
  import fetch_unit_pkg::*;

  // Byte span of instruction memory; 33 bits so a 30-bit word index still fits.
  localparam logic [32:0] SPAN = 33'd4 << ADR_BITS;

  logic [31:0] offset;

  // Addresses below the base wrap to a huge offset, so a single unsigned
  // compare covers both ends of the window.
  assign offset = pc - RESET_PC;

  always_comb begin
    exc_code = EXC_NONE;
    if ((pc[1:0] != 2'b00) || ({1'b0, offset} >= SPAN)) begin
      exc_code = EXC_ADEL;
    end
  end

endmodule
`endif

// File: rtl/fetch_unit.sv
// fetch_unit: PC generator and IF/ID pipeline register.
// Optional feature macro: FETCH_ADEL_CHECK_EN (alignment/range check on the
// fetch PC; when undefined exc_code_d is always 0 and instr_f always captured).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall                 hold PC and IF/ID (ignores redirect_en/branch_in_d)
//   redirect_en/_pc       taken branch/jump in D and its target
//   branch_in_d           D holds a branch/jump: next IF/ID entry is a delay slot
//   exc_req               exception entry (highest priority after reset)
//   eret_req, epc         exception return and its target
//   pc_f, instr_f         fetch PC to instruction memory, returned word
//   instr_d, pc_d, pc8_d  IF/ID instruction, PC, link address (pc_d + 8)
//   bd_d, exc_code_d      delay-slot flag, fetch exception code
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = fetch_unit_pkg::RESET_PC,
  parameter logic [31:0] HANDLER_PC = fetch_unit_pkg::HANDLER_PC
`ifdef FETCH_ADEL_CHECK_EN
  ,
  parameter int          ADR_BITS   = 12
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        branch_in_d,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        bd_d,
  output logic [4:0]  exc_code_d
);
  import fetch_unit_pkg::*;

  logic [31:0] pc_p0;
  logic [31:0] pc_next;
  logic [4:0]  fetch_exc;
  ifid_t       fetch_word;
  ifid_t       ifid_p1;

`ifdef FETCH_ADEL_CHECK_EN
  fetch_addr_check #(
    .RESET_PC (RESET_PC),
    .ADR_BITS (ADR_BITS)
  ) u_addr_check (
    .pc       (pc_p0),
    .exc_code (fetch_exc)
  );
`else
  assign fetch_exc = EXC_NONE;
`endif

  // Exception and eret override stall; redirect only counts once D commits.
  always_comb begin
    pc_next = pc_p0 + 32'd4;
    if (exc_req) begin
      pc_next = HANDLER_PC;
    end else if (eret_req) begin
      pc_next = epc;
    end else if (stall) begin
      pc_next = pc_p0;
    end else if (redirect_en) begin
      pc_next = redirect_pc;
    end
  end

  // A faulting fetch enters D as a nop tagged with its exception code.
  always_comb begin
    fetch_word.instr    = (fetch_exc == EXC_NONE) ? instr_f : NOP;
    fetch_word.pc       = pc_p0;
    fetch_word.bd       = branch_in_d;
    fetch_word.exc_code = fetch_exc;
  end

  // ---- stage boundary: F -> D (PC register and IF/ID register) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0   <= RESET_PC;
      ifid_p1 <= ifid_bubble(RESET_PC);
    end else begin
      pc_p0 <= pc_next;
      if (exc_req || eret_req) begin
        ifid_p1 <= ifid_bubble(pc_next);
      end else if (!stall) begin
        ifid_p1 <= fetch_word;
      end
    end
  end

  assign pc_f       = pc_p0;
  assign instr_d    = ifid_p1.instr;
  assign pc_d       = ifid_p1.pc;
  assign pc8_d      = ifid_p1.pc + 32'd8;
  assign bd_d       = ifid_p1.bd;
  assign exc_code_d = ifid_p1.exc_code;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized control inputs checked every cycle against a
// behavioural model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        branch_in_d = 1'b0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = 32'h0;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        bd_d;
  logic [4:0]  exc_code_d;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

`ifdef FETCH_ADEL_CHECK_EN
  localparam logic [4:0] ADEL_EXP = 5'd4;
`else
  localparam logic [4:0] ADEL_EXP = 5'd0;
`endif

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .branch_in_d (branch_in_d),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .pc_f        (pc_f),
    .instr_f     (instr_f),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc8_d       (pc8_d),
    .bd_d        (bd_d),
    .exc_code_d  (exc_code_d)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in: every address returns a distinct word.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, ~a[15:0]};
  endfunction

  assign instr_f = imem(pc_f);

  // Address is illegal if not word aligned or outside 0x3000..0x6FFF.
  function automatic bit adel(input logic [31:0] a);
`ifdef FETCH_ADEL_CHECK_EN
    return ((a % 4) != 0) || (a < 32'h3000) || (a >= 32'h7000);
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural model of the fetch stage state.
  logic [31:0] m_pc, m_instr, m_pcd;
  logic        m_bd;
  logic [4:0]  m_exc;

  always @(posedge clk) begin
    if (reset) begin
      m_pc    <= 32'h3000;
      m_instr <= 32'h0;
      m_pcd   <= 32'h3000;
      m_bd    <= 1'b0;
      m_exc   <= 5'd0;
    end else if (exc_req || eret_req) begin
      m_pc    <= exc_req ? 32'h4180 : epc;
      m_pcd   <= exc_req ? 32'h4180 : epc;
      m_instr <= 32'h0;
      m_bd    <= 1'b0;
      m_exc   <= 5'd0;
    end else if (!stall) begin
      m_pc    <= redirect_en ? redirect_pc : m_pc + 32'd4;
      m_pcd   <= m_pc;
      m_instr <= adel(m_pc) ? 32'h0 : imem(m_pc);
      m_bd    <= branch_in_d;
      m_exc   <= adel(m_pc) ? 5'd4 : 5'd0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_f",       pc_f,               m_pc);
      chk("instr_d",    instr_d,            m_instr);
      chk("pc_d",       pc_d,               m_pcd);
      chk("pc8_d",      pc8_d,              m_pcd + 32'd8);
      chk("bd_d",       32'(bd_d),          32'(m_bd));
      chk("exc_code_d", 32'(exc_code_d),    32'(m_exc));
    end
  end

  task automatic lit(input string tag, input logic [31:0] e_pcf, input logic [31:0] e_pcd,
                     input logic [31:0] e_instr, input logic e_bd, input logic [4:0] e_exc);
    chk({tag, ".pc_f"},    pc_f,            e_pcf);
    chk({tag, ".pc_d"},    pc_d,            e_pcd);
    chk({tag, ".pc8_d"},   pc8_d,           e_pcd + 32'd8);
    chk({tag, ".instr_d"}, instr_d,         e_instr);
    chk({tag, ".bd_d"},    32'(bd_d),       32'(e_bd));
    chk({tag, ".exc"},     32'(exc_code_d), 32'(e_exc));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall = 1'b0; redirect_en = 1'b0; branch_in_d = 1'b0;
    exc_req = 1'b0; eret_req = 1'b0; reset = 1'b0;
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] base;
    base = 32'h3000 + ($urandom_range(0, 4095) << 2);
    case ($urandom_range(0, 9))
      0:       return 32'h0000_2FFC;
      1:       return 32'h0000_7000;
      2:       return base + 32'($urandom_range(1, 3));
      3:       return 32'hFFFF_FFFC;
      default: return base;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    lit("reset", 32'h3000, 32'h3000, 32'h0, 1'b0, 5'd0);

    step(); lit("seq1", 32'h3004, 32'h3000, imem(32'h3000), 1'b0, 5'd0);
    step(); lit("seq2", 32'h3008, 32'h3004, imem(32'h3004), 1'b0, 5'd0);

    // Stall with a redirect and branch flag that must be ignored.
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h3100; branch_in_d = 1'b1;
    step(); lit("stall1", 32'h3008, 32'h3004, imem(32'h3004), 1'b0, 5'd0);
    step(); lit("stall2", 32'h3008, 32'h3004, imem(32'h3004), 1'b0, 5'd0);
    clear_in();
    step(); lit("resume", 32'h300C, 32'h3008, imem(32'h3008), 1'b0, 5'd0);
    step(); lit("seq3",   32'h3010, 32'h300C, imem(32'h300C), 1'b0, 5'd0);

    // Taken branch: delay slot enters D with bd set.
    redirect_en = 1'b1; redirect_pc = 32'h3100; branch_in_d = 1'b1;
    step(); lit("redir",  32'h3100, 32'h3010, imem(32'h3010), 1'b1, 5'd0);
    clear_in();
    step(); lit("target", 32'h3104, 32'h3100, imem(32'h3100), 1'b0, 5'd0);

    redirect_en = 1'b1; redirect_pc = 32'h3020; branch_in_d = 1'b1;
    step(); lit("to3020", 32'h3020, 32'h3104, imem(32'h3104), 1'b1, 5'd0);
    clear_in();

    // Exception overrides stall.
    exc_req = 1'b1; stall = 1'b1;
    step(); lit("exc",    32'h4180, 32'h4180, 32'h0, 1'b0, 5'd0);
    clear_in();
    step(); lit("hndlr",  32'h4184, 32'h4180, imem(32'h4180), 1'b0, 5'd0);

    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3024;
    step(); lit("exc_eret", 32'h4180, 32'h4180, 32'h0, 1'b0, 5'd0);
    clear_in(); eret_req = 1'b1;
    step(); lit("eret",   32'h3024, 32'h3024, 32'h0, 1'b0, 5'd0);
    clear_in();
    step(); lit("post_eret", 32'h3028, 32'h3024, imem(32'h3024), 1'b0, 5'd0);

    // Misaligned and out-of-range fetches.
    redirect_en = 1'b1; redirect_pc = 32'h3102;
    step(); lit("to3102", 32'h3102, 32'h3028, imem(32'h3028), 1'b0, 5'd0);
    clear_in();
    step(); lit("mis", 32'h3106, 32'h3102,
                (ADEL_EXP != 5'd0) ? 32'h0 : imem(32'h3102), 1'b0, ADEL_EXP);
    redirect_en = 1'b1; redirect_pc = 32'h7000;
    step(); lit("to7000", 32'h7000, 32'h3106,
                (ADEL_EXP != 5'd0) ? 32'h0 : imem(32'h3106), 1'b0, ADEL_EXP);
    clear_in();
    step(); lit("oor", 32'h7004, 32'h7000,
                (ADEL_EXP != 5'd0) ? 32'h0 : imem(32'h7000), 1'b0, ADEL_EXP);

    // Reset wins over stall and redirect.
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h3100; reset = 1'b1;
    step(); lit("rst_mid", 32'h3000, 32'h3000, 32'h0, 1'b0, 5'd0);
    clear_in();

    // Randomized control traffic, checked every cycle by the compare process.
    for (int i = 0; i < 800; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect_en = ($urandom_range(0, 5) == 0);
      branch_in_d = 1'($urandom_range(0, 1));
      exc_req     = ($urandom_range(0, 39) == 0);
      eret_req    = ($urandom_range(0, 39) == 0);
      redirect_pc = pick_target();
      epc         = pick_target();
      step();
    end
    clear_in();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
